// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, ALU ops
// and the bundle of control enables produced by the decoder.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_ERR  = 3'd6,
      S_BAD  = 3'd7
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_OR    = 3'd2;
   localparam logic [2:0] ALU_FUNCT = 3'd3;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;

   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       pc_we;
      logic       ir_we;
      logic       reg_we;
      logic       alu_src_b;
      logic       mem_to_reg;
      logic       ext_sel;
      logic [1:0] pc_src;
      logic [1:0] reg_dst;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Datapath-facing bundle of the control unit: master is the controller,
// slave is the datapath/memory side that supplies opcode, flags and readies.
interface mc_control_unit_if #(
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
);
   logic [5:0]         opcode;
   logic               zero;
   logic               imem_ready;
   logic               dmem_ready;
   logic               imem_req;
   logic               dmem_req;
   logic               dmem_we;
   logic               pc_we;
   logic               ir_we;
   logic               reg_we;
   logic               alu_src_b;
   logic               mem_to_reg;
   logic               ext_sel;
   logic [1:0]         pc_src;
   logic [1:0]         reg_dst;
   logic [ALUOP_W-1:0] alu_op;
   logic [2:0]         state;
   logic [CNT_W-1:0]   retired;
   logic               halted;
   logic               error;

   modport master (
      input  opcode, zero, imem_ready, dmem_ready,
      output imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we, alu_src_b,
             mem_to_reg, ext_sel, pc_src, reg_dst, alu_op, state, retired,
             halted, error
   );

   modport slave (
      output opcode, zero, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we, alu_src_b,
             mem_to_reg, ext_sel, pc_src, reg_dst, alu_op, state, retired,
             halted, error
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational decode: from current state, opcode, flags and readies produce
// the control enables, the ALU op and the next state.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3
) (
   input  state_e             state,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   input  logic               wait_hit,
   output ctrl_t              ctrl,
   output logic [ALUOP_W-1:0] alu_op,
   output state_e             state_nxt
);

   always_comb begin
      ctrl      = '0;
      alu_op    = ALUOP_W'(ALU_ADD);
      state_nxt = state;
      case (state)
         S_IF: begin
            ctrl.imem_req = 1'b1;
            if (imem_ready) begin
               ctrl.ir_we  = 1'b1;
               ctrl.pc_we  = 1'b1;
               ctrl.pc_src = PC_SEQ;
               state_nxt   = S_ID;
            end else if (wait_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_ID: begin
            if (opcode == OP_J) begin
               ctrl.pc_we  = 1'b1;
               ctrl.pc_src = PC_JMP;
               state_nxt   = S_IF;
            end else if (opcode == OP_HALT) begin
               state_nxt = S_HALT;
            end else if (!op_legal(opcode)) begin
               state_nxt = S_ERR;
            end else begin
               state_nxt = S_EXE;
            end
         end
         S_EXE: begin
            case (opcode)
               OP_BEQ: begin
                  alu_op      = ALUOP_W'(ALU_SUB);
                  ctrl.pc_src = PC_BR;
                  ctrl.pc_we  = zero;
                  state_nxt   = S_IF;
               end
               OP_LW, OP_SW: begin
                  ctrl.alu_src_b = 1'b1;
                  ctrl.ext_sel   = 1'b1;
                  state_nxt      = S_MEM;
               end
               OP_R: begin
                  alu_op    = ALUOP_W'(ALU_FUNCT);
                  state_nxt = S_WB;
               end
               OP_ADDI: begin
                  ctrl.alu_src_b = 1'b1;
                  ctrl.ext_sel   = 1'b1;
                  state_nxt      = S_WB;
               end
               OP_ORI: begin
                  ctrl.alu_src_b = 1'b1;
                  alu_op         = ALUOP_W'(ALU_OR);
                  state_nxt      = S_WB;
               end
               default: state_nxt = S_ERR;
            endcase
         end
         S_MEM: begin
            ctrl.dmem_req = 1'b1;
            ctrl.dmem_we  = (opcode == OP_SW);
            if (dmem_ready) begin
               if (opcode == OP_LW) state_nxt = S_WB;
               else                 state_nxt = S_IF;
            end else if (wait_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_WB: begin
            ctrl.reg_we     = 1'b1;
            ctrl.mem_to_reg = (opcode == OP_LW);
            ctrl.reg_dst    = (opcode == OP_R) ? 2'd1 : 2'd0;
            state_nxt       = S_IF;
         end
         S_HALT, S_ERR: state_nxt = state;
         default:       state_nxt = S_ERR;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: state register, memory wait timeout and a
// saturating retired-instruction counter around the combinational decoder.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   mc_control_unit_if.master  bus
);

   state_e             state_q, state_d;
   logic [7:0]         wait_q, wait_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   ctrl_t              ctrl, ctrl_g;
   logic [ALUOP_W-1:0] alu_op;
   logic               rdy, wait_hit;

   always_comb begin
      rdy      = (state_q == S_IF) ? bus.imem_ready : bus.dmem_ready;
      wait_hit = (wait_q == 8'(TIMEOUT));
   end

   mc_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_dec (
      .state      (state_q),
      .opcode     (bus.opcode),
      .zero       (bus.zero),
      .imem_ready (bus.imem_ready),
      .dmem_ready (bus.dmem_ready),
      .wait_hit   (wait_hit),
      .ctrl       (ctrl),
      .alu_op     (alu_op),
      .state_nxt  (state_d)
   );

   // Counter is zero outside IF/MEM, so every entry into them starts clean.
   always_comb begin
      wait_d = '0;
      if ((state_q == S_IF || state_q == S_MEM) && !rdy) wait_d = wait_q + 8'd1;
      retired_d = retired_q;
      if (state_d == S_IF && (state_q inside {S_ID, S_EXE, S_MEM, S_WB}) &&
          retired_q != '1)
         retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IF;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   // Nothing may be requested or written while reset is held.
   always_comb ctrl_g = rst ? '0 : ctrl;

   assign bus.imem_req   = ctrl_g.imem_req;
   assign bus.dmem_req   = ctrl_g.dmem_req;
   assign bus.dmem_we    = ctrl_g.dmem_we;
   assign bus.pc_we      = ctrl_g.pc_we;
   assign bus.ir_we      = ctrl_g.ir_we;
   assign bus.reg_we     = ctrl_g.reg_we;
   assign bus.alu_src_b  = ctrl_g.alu_src_b;
   assign bus.mem_to_reg = ctrl_g.mem_to_reg;
   assign bus.ext_sel    = ctrl_g.ext_sel;
   assign bus.pc_src     = ctrl_g.pc_src;
   assign bus.reg_dst    = ctrl_g.reg_dst;
   assign bus.alu_op     = alu_op;
   assign bus.state      = state_q;
   assign bus.retired    = retired_q;
   assign bus.halted     = (state_q == S_HALT);
   assign bus.error      = (state_q == S_ERR);

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: instruction walks, memory stalls,
// timeout, halt/illegal and reset abort, all against hand-derived values.
module tb_mc_control_unit;
   import mc_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;

   mc_control_unit_if #(.ALUOP_W(3), .CNT_W(16)) bus ();

   mc_control_unit #(.ALUOP_W(3), .CNT_W(16), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic nx();
      @(negedge clk);
      #1;
   endtask

   // Entered in an IF window; leaves in the ID window of the fetched opcode.
   task automatic fetch(input logic [5:0] op);
      bus.opcode     = op;
      bus.imem_ready = 1'b1;
      #1;
      chk("if_state", bus.state, S_IF);
      chk("if_ir_we", bus.ir_we, 1);
      chk("if_pc_we", bus.pc_we, 1);
      chk("if_pc_src", bus.pc_src, 0);
      nx();
      bus.imem_ready = 1'b0;
      chk("id_state", bus.state, S_ID);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.opcode = OP_R;
      bus.zero = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #3;
      chk("rst_state", bus.state, S_IF);
      chk("rst_retired", bus.retired, 0);
      chk("rst_imem_req", bus.imem_req, 0);
      chk("rst_error", bus.error, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_imem_req", bus.imem_req, 1);

      // ADDI: IF->ID->EXE->WB->IF
      fetch(OP_ADDI);
      chk("addi_id_reg_we", bus.reg_we, 0);
      nx();
      chk("addi_exe_state", bus.state, S_EXE);
      chk("addi_exe_srcb", bus.alu_src_b, 1);
      chk("addi_exe_ext", bus.ext_sel, 1);
      chk("addi_exe_aluop", bus.alu_op, ALU_ADD);
      chk("addi_exe_reg_we", bus.reg_we, 0);
      nx();
      chk("addi_wb_state", bus.state, S_WB);
      chk("addi_wb_reg_we", bus.reg_we, 1);
      chk("addi_wb_reg_dst", bus.reg_dst, 0);
      chk("addi_wb_m2r", bus.mem_to_reg, 0);
      chk("addi_wb_retired", bus.retired, 0);
      nx();
      chk("addi_if_state", bus.state, S_IF);
      chk("addi_retired", bus.retired, 1);
      chk("addi_if_reg_we", bus.reg_we, 0);

      // LW with dmem_ready three cycles late
      fetch(OP_LW);
      nx();
      chk("lw_exe_state", bus.state, S_EXE);
      chk("lw_exe_srcb", bus.alu_src_b, 1);
      chk("lw_exe_ext", bus.ext_sel, 1);
      nx();
      for (int i = 0; i < 3; i++) begin
         chk("lw_mem_state", bus.state, S_MEM);
         chk("lw_mem_req", bus.dmem_req, 1);
         chk("lw_mem_we", bus.dmem_we, 0);
         nx();
      end
      bus.dmem_ready = 1'b1;
      #1;
      chk("lw_mem4_state", bus.state, S_MEM);
      chk("lw_mem4_req", bus.dmem_req, 1);
      nx();
      bus.dmem_ready = 1'b0;
      chk("lw_wb_state", bus.state, S_WB);
      chk("lw_wb_m2r", bus.mem_to_reg, 1);
      chk("lw_wb_reg_we", bus.reg_we, 1);
      nx();
      chk("lw_retired", bus.retired, 2);

      // BEQ taken then not taken
      fetch(OP_BEQ);
      nx();
      bus.zero = 1'b1;
      #1;
      chk("beq1_state", bus.state, S_EXE);
      chk("beq1_pc_we", bus.pc_we, 1);
      chk("beq1_pc_src", bus.pc_src, 1);
      chk("beq1_aluop", bus.alu_op, ALU_SUB);
      nx();
      chk("beq1_if", bus.state, S_IF);
      chk("beq1_retired", bus.retired, 3);
      fetch(OP_BEQ);
      nx();
      bus.zero = 1'b0;
      #1;
      chk("beq0_pc_we", bus.pc_we, 0);
      chk("beq0_pc_src", bus.pc_src, 1);
      nx();
      chk("beq0_if", bus.state, S_IF);
      chk("beq0_retired", bus.retired, 4);

      // J resolves in ID
      fetch(OP_J);
      chk("j_pc_we", bus.pc_we, 1);
      chk("j_pc_src", bus.pc_src, 2);
      nx();
      chk("j_if", bus.state, S_IF);
      chk("j_retired", bus.retired, 5);

      // R-type: FUNCT op, rd destination
      fetch(OP_R);
      nx();
      chk("r_aluop", bus.alu_op, ALU_FUNCT);
      chk("r_srcb", bus.alu_src_b, 0);
      nx();
      chk("r_reg_dst", bus.reg_dst, 1);
      nx();
      chk("r_retired", bus.retired, 6);

      // ORI
      fetch(OP_ORI);
      nx();
      chk("ori_aluop", bus.alu_op, ALU_OR);
      chk("ori_ext", bus.ext_sel, 0);
      nx();
      nx();
      chk("ori_retired", bus.retired, 7);

      // HALT is absorbing, retired unchanged
      fetch(OP_HALT);
      nx();
      chk("halt_state", bus.state, S_HALT);
      chk("halt_flag", bus.halted, 1);
      chk("halt_retired", bus.retired, 7);
      bus.imem_ready = 1'b1;
      nx();
      chk("halt_sticky", bus.state, S_HALT);
      chk("halt_imem_req", bus.imem_req, 0);
      bus.imem_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("halt_rst_state", bus.state, S_IF);
      chk("halt_rst_retired", bus.retired, 0);
      nx();
      rst = 1'b0;
      #1;

      // SW completing immediately
      fetch(OP_SW);
      nx();
      nx();
      bus.dmem_ready = 1'b1;
      #1;
      chk("sw_mem_we", bus.dmem_we, 1);
      chk("sw_mem_req", bus.dmem_req, 1);
      nx();
      bus.dmem_ready = 1'b0;
      chk("sw_if", bus.state, S_IF);
      chk("sw_retired", bus.retired, 1);

      // reset asserted in MEM with a pending SW
      fetch(OP_SW);
      nx();
      nx();
      chk("swr_mem_we", bus.dmem_we, 1);
      rst = 1'b1;
      #1;
      chk("swr_we_drop", bus.dmem_we, 0);
      chk("swr_req_drop", bus.dmem_req, 0);
      chk("swr_state", bus.state, S_IF);
      chk("swr_retired", bus.retired, 0);
      bus.imem_ready = 1'b1;
      #1;
      chk("swr_hold_imem_req", bus.imem_req, 0);
      chk("swr_hold_ir_we", bus.ir_we, 0);
      nx();
      chk("swr_hold_state", bus.state, S_IF);
      bus.imem_ready = 1'b0;
      rst = 1'b0;
      #1;
      chk("swr_restart_req", bus.imem_req, 1);

      // illegal opcode
      fetch(6'b010101);
      nx();
      chk("ill_state", bus.state, S_ERR);
      chk("ill_error", bus.error, 1);
      chk("ill_retired", bus.retired, 0);
      rst = 1'b1;
      nx();
      rst = 1'b0;
      #1;

      // imem_ready never arrives: 16 IF cycles then ERR
      for (int i = 0; i < 16; i++) begin
         chk("to_if_state", bus.state, S_IF);
         nx();
      end
      chk("to_err_state", bus.state, S_ERR);
      chk("to_err_flag", bus.error, 1);
      bus.imem_ready = 1'b1;
      nx();
      chk("to_err_sticky", bus.state, S_ERR);
      chk("to_err_imem_req", bus.imem_req, 0);
      rst = 1'b1;
      #1;
      chk("to_rst_state", bus.state, S_IF);
      chk("to_rst_error", bus.error, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
